// File: rtl/shift_reg_seq_ctrl_if.sv
// Command channel for shift_reg_seq_ctrl: one transfer per valid/ready handshake.
interface shift_reg_seq_ctrl_if #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_len;
  logic [SIZE-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_len, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_len, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer for the universal shift register: LOAD -> N shifts -> DONE,
// capturing the final register contents into rx_data.
module shift_reg_seq_ctrl #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_reg_seq_ctrl_if.slave cmd,
  input  logic                abort,
  input  logic                ser_in,
  output logic [1:0]          sr_mode,
  output logic [SIZE-1:0]     sr_prl_in,
  output logic                sr_srl_in,
  input  logic [SIZE-1:0]     sr_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [SIZE-1:0]     rx_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic             dir;
  logic [SIZE-1:0]  data;
  logic             handshake;
  logic             abort_ok;

  assign handshake = cmd.cmd_valid && (state == IDLE);
  assign abort_ok  = abort && ((state == LOAD) || (state == SHIFT));

  // Zero or oversize lengths run a full-width transfer.
  assign len_clamped = ((cmd.cmd_len == '0) || (cmd.cmd_len > LEN_W'(SIZE)))
                       ? LEN_W'(SIZE) : cmd.cmd_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      dir     <= 1'b0;
      data    <= '0;
      rx_data <= '0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      aborted <= abort_ok;
      case (state)
        IDLE: begin
          if (handshake) begin
            dir   <= cmd.cmd_dir;
            data  <= cmd.cmd_data;
            len_q <= len_clamped;
          end
        end
        LOAD:    cnt     <= len_q;
        SHIFT:   cnt     <= cnt - LEN_W'(1);
        DONE:    rx_data <= sr_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = LOAD;
      LOAD:    state_nxt = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)                   state_nxt = IDLE;
        else if (cnt == LEN_W'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sr_mode   = 2'b00;
    sr_srl_in = 1'b0;
    case (state)
      LOAD:  sr_mode = 2'b11;
      SHIFT: begin
        sr_mode   = dir ? 2'b10 : 2'b01;
        sr_srl_in = ser_in;
      end
      default: ;
    endcase
  end

  assign sr_prl_in     = data;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign cmd.cmd_ready = (state == IDLE);

endmodule
